// File: rtl/dram_stream_reader.sv
// DRAM-to-stream read engine: issues Avalon-MM burst reads under FIFO credit control
// and forwards returned beats to the downstream FIFO write port.
module dram_stream_reader #(
   parameter int DATA_W     = 512,
   parameter int ADDR_W     = 64,
   parameter int BURST_W    = 3,
   parameter int MAX_BURST  = 4,
   parameter int COUNT_W    = 64,
   parameter int FIFO_DEPTH = 256,
   parameter int USEDW_W    = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [COUNT_W-1:0]  beat_count,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic                proto_err,
   output logic [COUNT_W-1:0]  beats_issued,
   output logic [COUNT_W-1:0]  beats_received,
   output logic [ADDR_W-1:0]   m_address,
   output logic [BURST_W-1:0]  m_burstcount,
   output logic                m_read,
   output logic [DATA_W/8-1:0] m_byteenable,
   input  logic                m_waitrequest,
   input  logic [DATA_W-1:0]   m_readdata,
   input  logic                m_readdatavalid,
   output logic [DATA_W-1:0]   dout,
   output logic                dout_valid,
   input  logic [USEDW_W-1:0]  fifo_usedw
);
   localparam int BYTES   = DATA_W / 8;
   localparam int BYTE_SH = $clog2(BYTES);
   // Credit sum is formed wide enough that no operand can wrap it.
   localparam int SUM_W   = ((COUNT_W > USEDW_W) ? COUNT_W : USEDW_W) + 2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [ADDR_W-1:0]   r_base;
   logic [COUNT_W-1:0]  r_len;
   logic [COUNT_W-1:0]  r_issued;
   logic [COUNT_W-1:0]  r_received;
   logic [COUNT_W-1:0]  r_outstanding;
   logic                r_read;
   logic [ADDR_W-1:0]   r_address;
   logic [BURST_W-1:0]  r_burstcount;
   logic [DATA_W-1:0]   r_dout;
   logic                r_dout_valid;
   logic                r_done;
   logic                r_aborted;
   logic                r_abort_pend;
   logic                r_proto_err;

   logic [COUNT_W-1:0]  w_remaining;
   logic [BURST_W-1:0]  w_burst;
   logic [SUM_W-1:0]    w_credit_sum;
   logic                w_credit_ok;
   logic                w_accept;
   logic                w_abort_any;
   logic                w_rv_ok;
   logic                w_rv_err;
   logic                w_busy;
   logic                w_start_ok;
   logic                w_issue;

   assign w_remaining  = r_len - r_issued;
   assign w_accept     = r_read & ~m_waitrequest;
   assign w_abort_any  = r_abort_pend | abort;
   assign w_rv_ok      = m_readdatavalid && (r_state != S_IDLE) && (r_outstanding != '0);
   assign w_rv_err     = m_readdatavalid && !w_rv_ok;

   always_comb begin
      w_burst = w_remaining[BURST_W-1:0];
      if (w_remaining >= COUNT_W'(MAX_BURST)) begin
         w_burst = BURST_W'(MAX_BURST);
      end
   end

   assign w_credit_sum = SUM_W'(fifo_usedw) + SUM_W'(r_outstanding)
                       + SUM_W'(r_dout_valid) + SUM_W'(w_burst);
   assign w_credit_ok  = (w_credit_sum <= SUM_W'(FIFO_DEPTH));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (beat_count == '0) ? S_FINISH : S_ISSUE;
            end
         end
         S_ISSUE: begin
            // A request on the bus is never withdrawn; leave only once it is gone.
            if (!r_read && ((r_issued == r_len) || w_abort_any)) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_outstanding == '0) begin
               w_state_next = S_FINISH;
            end
         end
         S_FINISH: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State-decoded control
   always_comb begin
      w_busy     = (r_state != S_IDLE);
      w_start_ok = start && (r_state == S_IDLE);
      w_issue    = (r_state == S_ISSUE) && !r_read && w_credit_ok
                   && !w_abort_any && (w_remaining != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_base        <= '0;
         r_len         <= '0;
         r_issued      <= '0;
         r_received    <= '0;
         r_outstanding <= '0;
         r_read        <= 1'b0;
         r_address     <= '0;
         r_burstcount  <= BURST_W'(1);
         r_dout        <= '0;
         r_dout_valid  <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         r_abort_pend  <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         r_done <= (r_state == S_FINISH);

         if (w_start_ok) begin
            r_base       <= src_addr;
            r_len        <= beat_count;
            r_issued     <= '0;
            r_received   <= '0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_proto_err  <= 1'b0;
         end

         if (abort && w_busy) begin
            r_abort_pend <= 1'b1;
            r_aborted    <= 1'b1;
         end

         if (w_issue) begin
            r_read       <= 1'b1;
            r_address    <= r_base + (ADDR_W'(r_issued) << BYTE_SH);
            r_burstcount <= w_burst;
         end else if (w_accept) begin
            r_read   <= 1'b0;
            r_issued <= r_issued + COUNT_W'(r_burstcount);
         end

         r_outstanding <= r_outstanding
                        + (w_accept ? COUNT_W'(r_burstcount) : '0)
                        - (w_rv_ok ? COUNT_W'(1) : '0);

         r_dout_valid <= w_rv_ok;
         if (w_rv_ok) begin
            r_dout     <= m_readdata;
            r_received <= r_received + COUNT_W'(1);
         end

         // Stray beats are dropped but flagged; this wins over the start clear.
         if (w_rv_err) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign busy           = w_busy;
   assign done           = r_done;
   assign aborted        = r_aborted;
   assign proto_err      = r_proto_err;
   assign beats_issued   = r_issued;
   assign beats_received = r_received;
   assign m_address      = r_address;
   assign m_burstcount   = r_burstcount;
   assign m_read         = r_read;
   assign m_byteenable   = '1;
   assign dout           = r_dout;
   assign dout_valid     = r_dout_valid;

endmodule

// File: doc/dram_stream_reader.md
Name: dram_stream_reader

Overview:
- Parametrised DRAM-to-stream read engine; next generation of the DRAM->receive-FIFO path that feeds the mspe core array.
- Issues Avalon-MM burst reads with full waitrequest compliance.
- Tracks outstanding beats and applies credit-based flow control against the downstream FIFO, so the FIFO can never overflow.
- Supports start/abort control, a done pulse and status counters for the CSR block.

Parameters:
- DATA_W, 512, data bus width in bits; byte count per beat BYTES = DATA_W/8.
- ADDR_W, 64, byte address width.
- BURST_W, 3, width of m_burstcount.
- MAX_BURST, 4, largest burst issued; must be at most 2^(BURST_W-1).
- COUNT_W, 64, width of the transfer-length and counter fields, in beats.
- FIFO_DEPTH, 256, capacity in words of the downstream FIFO.
- USEDW_W, 11, width of fifo_usedw.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- abort  in  1  one-cycle pulse; stops issuing new bursts
- src_addr  in  ADDR_W  byte base address; must be BYTES-aligned
- beat_count  in  COUNT_W  transfer length in beats
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at completion
- aborted  out  1  sticky; set by abort, cleared by start
- proto_err  out  1  sticky; unexpected readdatavalid; cleared by start
- beats_issued  out  COUNT_W  beats accepted by the slave
- beats_received  out  COUNT_W  beats forwarded to dout
- m_address  out  ADDR_W  Avalon read address
- m_burstcount  out  BURST_W  Avalon burst length
- m_read  out  1  Avalon read request
- m_byteenable  out  DATA_W/8  Avalon byte enables; constant all-ones
- m_waitrequest  in  1  Avalon wait
- m_readdata  in  DATA_W  Avalon read data
- m_readdatavalid  in  1  Avalon read-data valid
- dout  out  DATA_W  data to the FIFO write port
- dout_valid  out  1  FIFO wrreq
- fifo_usedw  in  USEDW_W  FIFO fill level; reflects a write one cycle after wrreq

Behaviour:
- Reset values:
  - Outputs: m_read=0, m_address=0, m_burstcount=1, dout=0, dout_valid=0, busy=0, done=0, aborted=0, proto_err=0, both counters=0.
  - Internal: outstanding=0, state=IDLE.
- States and transitions:
  - IDLE: on start, latch src_addr and beat_count; clear counters, aborted and proto_err.
    - If beat_count==0, go to FINISH.
    - Otherwise go to ISSUE.
  - ISSUE: burst length b = min(MAX_BURST, beat_count - beats_issued).
    - Credit condition: fifo_usedw + outstanding + dout_valid + b <= FIFO_DEPTH, evaluated at full width with no truncation.
    - When m_read is low and credit holds, assert m_read next cycle with m_address = base + beats_issued*BYTES (modulo 2^ADDR_W) and m_burstcount = b.
    - While m_waitrequest=1, hold m_read, m_address and m_burstcount stable.
    - On acceptance (m_read & !m_waitrequest): beats_issued += b; outstanding += b; deassert m_read the next cycle. Back-to-back issue is not required.
    - Go to DRAIN when beats_issued reaches beat_count, or when abort is pending and no request is in flight on the bus.
  - DRAIN: wait for outstanding==0, then go to FINISH.
  - FINISH: pulse done for one cycle, then return to IDLE.
- Abort:
  - Latched as pending in any busy state.
  - A request already asserted is never withdrawn; it completes acceptance first.
  - All data already requested is still received and forwarded.
  - Sets aborted.
  - Ignored in IDLE.
- Return path:
  - Registered with 1-cycle latency: dout <= m_readdata and dout_valid <= m_readdatavalid, when valid is accepted.
  - Each accepted beat: outstanding -= 1 and beats_received += 1.
  - If acceptance and a return occur in the same cycle, outstanding += b-1.
- Protocol errors:
  - m_readdatavalid while outstanding==0, or in IDLE: sets proto_err.
  - The beat is dropped (no dout_valid) and is not counted.
- start while busy: ignored.
- Reset mid-transfer:
  - All state clears and the block returns to IDLE.
  - The system resets the interconnect in the same cycle; late beats set proto_err.
- There is no boundary-split logic. Software places transfers so that bursts never cross an interconnect page.

Test Plan:
- Full-length run: src_addr=0x1000, beat_count=10, no waitrequest, fifo_usedw=0 -> bursts 4,4,2 at addresses 0x1000, 0x1100, 0x1200. Expect 10 dout_valid in order, a single done pulse, and beats_issued = beats_received = 10.
- Waitrequest hold: waitrequest held high for 5 cycles on the second burst -> m_read, m_address and m_burstcount stay stable for all 5 cycles; the burst is accepted exactly once.
- Credit stall: FIFO_DEPTH=256, fifo_usedw=253 -> no burst of 4 is issued. Lower usedw to 252 -> the burst issues next cycle. Outstanding plus FIFO level never exceeds 256.
- Abort: abort asserted while the third burst is waiting (beat_count=40) -> that burst still completes. Exactly 12 beats are forwarded; aborted=1; done pulses once.
- Zero length and errors: beat_count=0 -> done pulses 2 cycles after start with m_read never asserted. A stray readdatavalid in IDLE -> proto_err=1 with no dout_valid.
- Reset mid-transfer: reset while outstanding=4 -> all outputs return to reset values next cycle. A later start with beat_count=4 completes normally.
